// File: rtl/ball_renderer_if.sv
// ball_renderer_if: beam timing, ball position and ball graphics signals between sync/position logic and the renderer
interface ball_renderer_if #(parameter int POS_BITS = 9);
  logic [POS_BITS-1:0] hpos;
  logic [POS_BITS-1:0] vpos;
  logic                display_on;
  logic                frame_start;
  logic [POS_BITS-1:0] ball_hpos;
  logic [POS_BITS-1:0] ball_vpos;
  logic                ball_gfx;
  logic                ball_line;
  modport master (output hpos, vpos, display_on, frame_start, ball_hpos, ball_vpos,
                  input  ball_gfx, ball_line);
  modport slave  (input  hpos, vpos, display_on, frame_start, ball_hpos, ball_vpos,
                  output ball_gfx, ball_line);
endinterface

// File: rtl/ball_renderer.sv
// ball_renderer: per-pixel ball graphics from a once-per-frame latched position (BALL_RENDERER_ROUND_EN masks the four corners)
module ball_renderer #(
  parameter int BALL_SIZE = 4,
  parameter int POS_BITS  = 9
) (
  input logic             clk,
  input logic             reset,
  ball_renderer_if.slave  bus
);
  typedef enum logic {IDLE, DRAW} state_t;
  localparam logic [3:0] HMAX = 4'(BALL_SIZE - 1);
  localparam logic [4:0] VMAX = 5'(BALL_SIZE);
  logic [POS_BITS-1:0] lat_h_q, lat_v_q;
  logic [4:0]          vcnt_q, vcnt_d;
  logic [3:0]          hcnt_q, hcnt_d;
  state_t              state_q, state_d;
  logic                gfx_q, gfx_d;
  logic                line_start, start, load, corner;
  // next-state: line counter at line start, pixel run counter, masked pixel
  always_comb begin
    line_start = bus.hpos == '0;
    vcnt_d  = bus.frame_start ? 5'd0 :
              !line_start ? vcnt_q :
              (bus.vpos == lat_v_q) ? VMAX :
              (vcnt_q != 5'd0) ? vcnt_q - 5'd1 : 5'd0;
    start   = (vcnt_d != 5'd0) && (bus.hpos == lat_h_q);
    load    = !bus.frame_start && (state_q == IDLE || line_start);
    state_d = bus.frame_start ? IDLE :
              load ? (start ? DRAW : IDLE) :
              (hcnt_q == 4'd0) ? IDLE : DRAW;
    hcnt_d  = (load && start) ? HMAX :
              (!load && !bus.frame_start && hcnt_q != 4'd0) ? hcnt_q - 4'd1 : hcnt_q;
`ifdef BALL_RENDERER_ROUND_EN
    corner  = (BALL_SIZE >= 3) && (hcnt_d == HMAX || hcnt_d == 4'd0) &&
              (vcnt_d == VMAX || vcnt_d == 5'd1);
`else
    corner  = 1'b0;
`endif
    gfx_d   = (state_d == DRAW) && bus.display_on && !corner;
  end
  // state registers; frame_start latches the new ball position
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_h_q <= '0;
      lat_v_q <= '0;
      vcnt_q  <= '0;
      hcnt_q  <= '0;
      state_q <= IDLE;
      gfx_q   <= 1'b0;
    end else begin
      if (bus.frame_start) begin
        lat_h_q <= bus.ball_hpos;
        lat_v_q <= bus.ball_vpos;
      end
      vcnt_q  <= vcnt_d;
      hcnt_q  <= hcnt_d;
      state_q <= state_d;
      gfx_q   <= gfx_d;
    end
  end
  assign bus.ball_gfx  = gfx_q;
  assign bus.ball_line = vcnt_q != 5'd0;
endmodule

// File: tb/tb_ball_renderer.sv
// tb_ball_renderer: directed frames with hand-computed pixel counts and extents per line
`timescale 1ns/1ps
module tb_ball_renderer;
`ifdef BALL_RENDERER_ROUND_EN
  localparam int R = 1;
`else
  localparam int R = 0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  ball_renderer_if #(.POS_BITS(9)) bi();
  ball_renderer #(.BALL_SIZE(4), .POS_BITS(9)) dut (.clk(clk), .reset(reset), .bus(bi));
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  int cnt[0:511], mn[0:511], mx[0:511];
  logic bl[0:511];
  int tot, ph = 5, pv = 250;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic clr();
    for (int i = 0; i < 512; i++) begin
      cnt[i] = 0; mn[i] = 999; mx[i] = -1; bl[i] = 1'b0;
    end
    tot = 0;
  endtask
  task automatic cyc(input int h, input int v, input logic fs);
    @(posedge clk); #1;
    if (bi.ball_gfx) begin
      cnt[pv]++; tot++;
      if (ph < mn[pv]) mn[pv] = ph;
      if (ph > mx[pv]) mx[pv] = ph;
    end
    bi.hpos = 9'(h); bi.vpos = 9'(v); bi.frame_start = fs;
    bi.display_on = (h < 256) && (v < 240);
    ph = h; pv = v;
  endtask
  task automatic run_line(input int v);
    for (int h = 0; h < 260; h++) cyc(h, v, 1'b0);
    bl[v] = bi.ball_line;
  endtask
  task automatic fstart(input int bh, input int bv);
    bi.ball_hpos = 9'(bh); bi.ball_vpos = 9'(bv);
    cyc(5, 250, 1'b1);
    cyc(6, 250, 1'b0);
  endtask
  task automatic frame(input int bh, input int bv, input int lo, input int hi);
    clr();
    fstart(bh, bv);
    for (int v = lo; v <= hi; v++) run_line(v);
    cyc(5, 250, 1'b0);
  endtask
  initial begin
    bi.hpos = 9'd5; bi.vpos = 9'd250; bi.display_on = 1'b0; bi.frame_start = 1'b0;
    bi.ball_hpos = '0; bi.ball_vpos = '0;
    clr();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gfx", int'(bi.ball_gfx), 0);
    chk("rst_line", int'(bi.ball_line), 0);
    #4 reset = 1'b1;
    // basic frame, ball_hpos changed mid-frame without frame_start
    clr();
    fstart(128, 120);
    for (int v = 118; v <= 125; v++) begin
      if (v == 121) bi.ball_hpos = 9'd40;
      run_line(v);
    end
    cyc(5, 250, 1'b0);
    chk("a_cnt119", cnt[119], 0);
    chk("a_cnt120", cnt[120], 4 - 2 * R);
    chk("a_mn120", mn[120], 128 + R);
    chk("a_cnt121", cnt[121], 4);
    chk("a_mn121", mn[121], 128);
    chk("a_mx121", mx[121], 131);
    chk("a_cnt124", cnt[124], 0);
    chk("a_tot", tot, 16 - 4 * R);
    chk("a_bl119", int'(bl[119]), 0);
    chk("a_bl120", int'(bl[120]), 1);
    chk("a_bl123", int'(bl[123]), 1);
    chk("a_bl124", int'(bl[124]), 0);
    // next frame picks up the new horizontal position
    clr();
    fstart(40, 120);
    for (int v = 118; v <= 125; v++) run_line(v);
    cyc(5, 250, 1'b0);
    chk("b_mn121", mn[121], 40);
    chk("b_mx121", mx[121], 43);
    chk("b_tot", tot, 16 - 4 * R);
    // ball at the origin
    frame(0, 0, 0, 5);
    chk("c_cnt0", cnt[0], 4 - 2 * R);
    chk("c_mn0", mn[0], R);
    chk("c_mn1", mn[1], 0);
    chk("c_mx1", mx[1], 3);
    chk("c_cnt3", cnt[3], 4 - 2 * R);
    chk("c_cnt4", cnt[4], 0);
    chk("c_tot", tot, 16 - 4 * R);
    // clipped by display_on at the end of the line, no wrap
    frame(254, 120, 119, 124);
    chk("d_cnt120", cnt[120], 2 - R);
    chk("d_mx120", mx[120], 255);
    chk("d_cnt121", cnt[121], 2);
    chk("d_mn121", mn[121], 254);
    chk("d_cnt124", cnt[124], 0);
    chk("d_tot", tot, 8 - 2 * R);
    // asynchronous reset in the middle of a draw
    clr();
    fstart(128, 120);
    run_line(119);
    for (int h = 0; h <= 130; h++) cyc(h, 120, 1'b0);
    chk("e_pre_gfx", int'(bi.ball_gfx), 1);
    #3 reset = 1'b0;
    #1;
    chk("e_rst_gfx", int'(bi.ball_gfx), 0);
    chk("e_rst_line", int'(bi.ball_line), 0);
    #3 reset = 1'b1;
    clr();
    for (int h = 131; h < 260; h++) cyc(h, 120, 1'b0);
    for (int v = 121; v <= 124; v++) run_line(v);
    cyc(5, 250, 1'b0);
    chk("e_post_tot", tot, 0);
    frame(128, 120, 119, 124);
    chk("e_new_tot", tot, 16 - 4 * R);
    // frame_start coincident with line start wins over the old latch
    fstart(60, 119);
    clr();
    bi.ball_hpos = 9'd60; bi.ball_vpos = 9'd120;
    cyc(0, 119, 1'b1);
    for (int h = 1; h < 260; h++) cyc(h, 119, 1'b0);
    for (int v = 120; v <= 124; v++) run_line(v);
    cyc(5, 250, 1'b0);
    chk("f_cnt119", cnt[119], 0);
    chk("f_cnt120", cnt[120], 4 - 2 * R);
    chk("f_mn121", mn[121], 60);
    chk("f_cnt124", cnt[124], 0);
    // corner shape at (100, 50)
    frame(100, 50, 49, 54);
    chk("g_cnt50", cnt[50], 4 - 2 * R);
    chk("g_mn50", mn[50], 100 + R);
    chk("g_mx50", mx[50], 103 - R);
    chk("g_mn51", mn[51], 100);
    chk("g_mx52", mx[52], 103);
    chk("g_cnt53", cnt[53], 4 - 2 * R);
    chk("g_tot", tot, 16 - 4 * R);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ball_renderer.md
Name: ball_renderer

Overview:
- Downstream consumer of the ball position logic. Converts the per-frame ball position into a per-pixel ball graphics signal, in step with the video beam position from the sync generator.
- Captures the ball position once per frame so the image never tears mid-frame.
- Runs per-line and per-pixel counters instead of full-width comparators; the output feeds the pixel mux / RGB stage.

Parameters:
- BALL_SIZE, 4, ball edge length in pixels and lines; legal range 1..15.
- POS_BITS, 9, width of all position buses.

Ports:
- clk  input  1  pixel clock.
- reset  input  1  asynchronous, active-low reset.
- hpos  input  POS_BITS  beam horizontal position from sync generator, 0 at line start.
- vpos  input  POS_BITS  beam vertical position from sync generator.
- display_on  input  1  high during visible area.
- frame_start  input  1  single-cycle pulse, once per frame, during vertical blank.
- ball_hpos  input  POS_BITS  ball left edge, from ball position logic.
- ball_vpos  input  POS_BITS  ball top edge, from ball position logic.
- ball_gfx  output  1  registered ball pixel.
- ball_line  output  1  high while the current line intersects the ball.

Behaviour:
- Reset (reset low, asynchronous):
  - Latched X and Y = 0.
  - Vertical line counter vcnt = 0.
  - Horizontal FSM = IDLE; pixel counter hcnt = 0.
  - ball_gfx = 0; ball_line = 0.
- Position latch:
  - On a clk edge with frame_start = 1, latch lat_h <= ball_hpos and lat_v <= ball_vpos.
  - The same edge clears vcnt to 0 and forces the FSM to IDLE, aborting any draw in progress.
  - Between frame_start pulses, changes on ball_hpos/ball_vpos have no effect.
- Line start is the cycle with hpos == 0.
- Vertical counter, evaluated at line start:
  - If vpos == lat_v: vcnt <= BALL_SIZE.
  - Else if vcnt != 0: vcnt <= vcnt - 1.
  - ball_line = (vcnt != 0), taken from the registered counter.
  - The ball therefore covers exactly BALL_SIZE lines, starting with line lat_v.
  - A match on the last line of the frame continues counting across vertical blank until the next frame_start clears vcnt.
- Horizontal FSM:
  - IDLE: if ball_line and hpos == lat_h, go to DRAW with hcnt <= BALL_SIZE - 1.
  - DRAW: if hcnt == 0, go to IDLE; else hcnt <= hcnt - 1.
  - Line start (hpos == 0) forces IDLE unless lat_h == 0, in which case it enters DRAW as above. A ball that straddles the end of a line is clipped, never wrapped onto the next line.
- Output:
  - ball_gfx <= (next state == DRAW) & display_on, registered.
  - Latency: the pixel at hpos == lat_h appears on ball_gfx one clock after hpos == lat_h is presented.
  - Run length: exactly BALL_SIZE consecutive cycles per covered line, unless clipped by display_on low or by line start.
- Width rules:
  - All compares are POS_BITS-wide equality tests, unsigned.
  - hcnt is 4 bits; vcnt is 5 bits.
  - If lat_h or lat_v is never reached by the beam (off-screen), there is no output and no error.
- Simultaneous frame_start and line start: frame_start takes priority. The new lat_v is used from the next line start onward.

Optional Feature:
- Macro: BALL_RENDERER_ROUND_EN.
- Defined: corner masking. ball_gfx is suppressed on the first and last pixel of the first and last covered line, giving a rounded ball. Only applies when BALL_SIZE >= 3.
- Not defined: square ball. Every pixel of the BALL_SIZE x BALL_SIZE box is lit.

Test Plan:
- Reset low mid-draw (ball_gfx = 1) -> ball_gfx and ball_line drop to 0 immediately (asynchronously); after release, no output until the next frame_start.
- frame_start with ball_hpos = 128, ball_vpos = 120, BALL_SIZE = 4 -> ball_gfx high for hpos 128..131, appearing one cycle late, on lines 120..123 only; 16 pixels per frame.
- Change ball_hpos to 40 mid-frame without frame_start -> current frame still draws at 128; next frame draws at 40.
- lat_h = 0, lat_v = 0 -> lines 0..3 each draw 4 pixels starting at hpos 0.
- lat_h = 254 with display_on falling at hpos 256 -> 2 pixels per line (254, 255); no pixels at hpos 0 of the following line.
- Define BALL_RENDERER_ROUND_EN, ball at (100, 50) -> lines 50 and 53 light hpos 101..102; lines 51..52 light hpos 100..103; 12 pixels total.
